// File: rtl/bus_breakout_pkg.sv
// Shared widths, output-stage state encoding and the breakout combine function
// for the two-requester bus breakout arbiter.
package bus_breakout_pkg;

    localparam int IN_W  = 4;
    localparam int OUT_W = 6;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Upper half of the first operand over the whole second operand.
    function automatic logic [OUT_W-1:0] breakout_combine(
        input logic [IN_W-1:0] in_1,
        input logic [IN_W-1:0] in_2
    );
        return {in_1[3:2], in_2[3:0]};
    endfunction

endpackage

// File: rtl/bus_breakout_core.sv
// Purely combinational breakout combiner; the arbiter instantiates it once
// on the operands of the winning requester.
module bus_breakout_core
    import bus_breakout_pkg::*;
(
    input  logic [IN_W-1:0]  in_1,
    input  logic [IN_W-1:0]  in_2,
    output logic [OUT_W-1:0] out_word
);

    assign out_word = breakout_combine(in_1, in_2);

endmodule

// File: rtl/bus_breakout_arbiter.sv
// Round-robin arbiter sharing one breakout combiner between two requesters,
// with a one-entry registered output stage and saturating grant counters.
module bus_breakout_arbiter
    import bus_breakout_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_in_1,
    input  logic [3:0]       req0_in_2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_in_1,
    input  logic [3:0]       req1_in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam logic             PRIO_RST = (PRIO_INIT != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    out_state_e       state_r;
    logic             prio_r;
    logic [OUT_W-1:0] out_data_r;
    logic             out_src_r;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    logic             can_accept_s;
    logic             grant_vld_s;
    logic             winner_s;
    logic             accept_s;
    logic [IN_W-1:0]  mux_in_1_s;
    logic [IN_W-1:0]  mux_in_2_s;
    logic [OUT_W-1:0] comb_out_s;

    // Winner selection: a lone valid wins, ties go to the priority pointer.
    always_comb begin
        grant_vld_s = 1'b0;
        winner_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld_s = 1'b1;
            winner_s    = prio_r;
        end else if (req0_valid) begin
            grant_vld_s = 1'b1;
            winner_s    = 1'b0;
        end else if (req1_valid) begin
            grant_vld_s = 1'b1;
            winner_s    = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            winner_s    = 1'b0;
        end
    end

    // Handshake qualification; readies are held low for the whole reset pulse.
    always_comb begin
        can_accept_s = (state_r == ST_EMPTY) || (out_ready && (state_r == ST_FULL));
        accept_s     = can_accept_s && grant_vld_s && !rst;
        req0_ready   = accept_s && (winner_s == 1'b0);
        req1_ready   = accept_s && (winner_s == 1'b1);
    end

    // Operand mux feeding the single shared combiner.
    always_comb begin
        if (winner_s) begin
            mux_in_1_s = req1_in_1;
            mux_in_2_s = req1_in_2;
        end else begin
            mux_in_1_s = req0_in_1;
            mux_in_2_s = req0_in_2;
        end
    end

    bus_breakout_core u_core (
        .in_1     (mux_in_1_s),
        .in_2     (mux_in_2_s),
        .out_word (comb_out_s)
    );

    // Output stage FSM: a load may coincide with a drain for full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_EMPTY;
            prio_r     <= PRIO_RST;
            out_data_r <= {OUT_W{1'b0}};
            out_src_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r    <= ST_FULL;
                        out_data_r <= comb_out_s;
                        out_src_r  <= winner_s;
                        prio_r     <= ~winner_s;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        state_r    <= ST_FULL;
                        out_data_r <= comb_out_s;
                        out_src_r  <= winner_s;
                        prio_r     <= ~winner_s;
                    end else if (out_ready) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && (winner_s == 1'b0) && (cnt0_r != CNT_MAX)) begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end
            if (accept_s && (winner_s == 1'b1) && (cnt1_r != CNT_MAX)) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end
        end
    end

    assign out_valid  = (state_r == ST_FULL);
    assign out_data   = out_data_r;
    assign out_src    = out_src_r;
    assign grant_cnt0 = cnt0_r;
    assign grant_cnt1 = cnt1_r;

endmodule

// File: tb/tb_bus_breakout_arbiter.sv
// Directed self-checking bench: arbitration, backpressure, drain, async reset
// and counter saturation (second instance with 2-bit counters).
module tb_bus_breakout_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_in_1, req0_in_2, req1_in_1, req1_in_2;
    logic       out_valid, out_ready, out_src;
    logic [5:0] out_data;
    logic [7:0] grant_cnt0, grant_cnt1;

    logic       b_req0_valid, b_req1_valid;
    logic       b_req0_ready, b_req1_ready;
    logic [3:0] b_req0_in_1, b_req0_in_2, b_req1_in_1, b_req1_in_2;
    logic       b_out_valid, b_out_ready, b_out_src;
    logic [5:0] b_out_data;
    logic [1:0] b_grant_cnt0, b_grant_cnt1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    bus_breakout_arbiter #(.CNT_W(8), .PRIO_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in_1(req0_in_1), .req0_in_2(req0_in_2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in_1(req1_in_1), .req1_in_2(req1_in_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    bus_breakout_arbiter #(.CNT_W(2), .PRIO_INIT(0)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
        .req0_in_1(b_req0_in_1), .req0_in_2(b_req0_in_2),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
        .req1_in_1(b_req1_in_1), .req1_in_2(b_req1_in_2),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_src(b_out_src),
        .grant_cnt0(b_grant_cnt0), .grant_cnt1(b_grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0; out_ready = 1'b1;
        req0_in_1 = 4'b1000; req0_in_2 = 4'b1011;
        req1_in_1 = 4'b0100; req1_in_2 = 4'b1110;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_out_ready = 1'b0;
        b_req0_in_1 = 4'b0000; b_req0_in_2 = 4'b0000;
        b_req1_in_1 = 4'b0100; b_req1_in_2 = 4'b1110;

        // Reset state, including readies forced low while rst is high.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_cnt0", 32'(grant_cnt0), 32'd0);
        check("rst_cnt1", 32'(grant_cnt1), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Contention from reset: grants alternate 0,1,0,1.
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check("cont_valid", 32'(out_valid), 32'd1);
            check("cont_src", 32'(out_src), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("cont_data", 32'(out_data), (i % 2 == 0) ? 32'd43 : 32'd30);
        end
        check("cont_cnt0", 32'(grant_cnt0), 32'd2);
        check("cont_cnt1", 32'(grant_cnt1), 32'd2);

        // Backpressure: three stalled cycles holding the req1 result.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd30);
            check("bp_src", 32'(out_src), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready0", 32'(req0_ready), 32'd1);
        check("bp_release_ready1", 32'(req1_ready), 32'd0);
        tick();
        check("bp_release_data", 32'(out_data), 32'd43);
        check("bp_release_src", 32'(out_src), 32'd0);
        check("bp_release_cnt0", 32'(grant_cnt0), 32'd3);

        // Drain with no refill.
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("drain1_valid", 32'(out_valid), 32'd0);
        check("drain1_data", 32'(out_data), 32'd43);

        // Single requester 0 while the pointer favours requester 1.
        req0_in_1 = 4'b1100; req0_in_2 = 4'b1010; req0_valid = 1'b1;
        #1;
        check("single_ready0", 32'(req0_ready), 32'd1);
        check("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'd58);
        check("single_src", 32'(out_src), 32'd0);
        check("single_cnt0", 32'(grant_cnt0), 32'd4);
        tick();
        check("drain2_valid", 32'(out_valid), 32'd0);
        check("drain2_data", 32'(out_data), 32'd58);
        tick();
        check("drain2_still_empty", 32'(out_valid), 32'd0);

        // Async reset between edges while FULL (pointer currently favours req1).
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_src", 32'(out_src), 32'd0);
        check("arst_cnt0", 32'(grant_cnt0), 32'd0);
        check("arst_cnt1", 32'(grant_cnt1), 32'd0);
        tick();
        rst = 1'b0;
        req0_in_1 = 4'b1000; req0_in_2 = 4'b1011;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("post_rst_ready0", 32'(req0_ready), 32'd1);
        check("post_rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("post_rst_src", 32'(out_src), 32'd0);
        check("post_rst_data", 32'(out_data), 32'd43);

        // Saturation of a 2-bit counter on the second instance.
        b_out_ready = 1'b1;
        b_req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_cnt1", 32'(b_grant_cnt1), 32'(exp_sat[i]));
            check("sat_cnt0", 32'(b_grant_cnt0), 32'd0);
        end
        check("sat_data", 32'(b_out_data), 32'd30);
        check("sat_src", 32'(b_out_src), 32'd1);
        b_req1_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
